// File: rtl/pipeline_ctrl.sv
// Pipeline sequencing controller for nand_cpu: stage enables, flushes and bubbles,
// hazard stalls, memory freezes, and the HLT / INT drain-and-enter flows.
module pipeline_ctrl #(
  parameter int ADDR_W      = 4,
  parameter int DRAIN_DEPTH = 2,
  parameter int CNT_W       = 16
) (
  input  logic              clk,
  input  logic              n_rst,
  input  logic              id_valid,
  input  logic              id_use_ra,
  input  logic              id_use_rt,
  input  logic              id_read_ps,
  input  logic              id_halt,
  input  logic              id_interrupt,
  input  logic [ADDR_W-1:0] id_rt_addr,
  input  logic [3:0]        id_immdt,
  input  logic              ex_valid,
  input  logic              ex_use_rw,
  input  logic              ex_write_ps,
  input  logic              ex_is_load,
  input  logic [ADDR_W-1:0] ex_rw_addr,
  input  logic              ex_redirect,
  input  logic              mem_req,
  input  logic              mem_ready,
  input  logic              resume,
  output logic              pc_en,
  output logic              if_id_en,
  output logic              id_ex_en,
  output logic              ex_mem_en,
  output logic              if_id_flush,
  output logic              id_ex_bubble,
  output logic              int_take,
  output logic [3:0]        int_code,
  output logic              halted,
  output logic [CNT_W-1:0]  stall_cnt
);

  localparam int DW = (DRAIN_DEPTH < 2) ? 1 : $clog2(DRAIN_DEPTH + 1);

  typedef enum logic [1:0] {
    S_RUN,
    S_DRAIN,
    S_HALTED,
    S_INT
  } state_t;

  state_t        state_q, state_d;
  logic [DW-1:0] drain_q, drain_d;
  logic          tgt_int_q, tgt_int_d;
  logic [3:0]    code_d;

  logic freeze;
  logic reads_rw;
  logic load_use;
  logic ps_hazard;
  logic drain_req;

  assign freeze    = mem_req && !mem_ready;
  // ra is architectural register 0, so a ra read collides with a write to address 0.
  assign reads_rw  = (id_use_ra && (ex_rw_addr == '0)) ||
                     (id_use_rt && (ex_rw_addr == id_rt_addr));
  assign load_use  = id_valid && ex_valid && ex_is_load && ex_use_rw && reads_rw;
  assign ps_hazard = id_valid && id_read_ps && ex_valid && ex_write_ps;
  assign drain_req = id_valid && (id_halt || id_interrupt);

  always_comb begin
    // NOTE: every output and next-state term gets a default here so that no path
    // through the case below leaves a variable unassigned and infers a latch.
    pc_en        = 1'b0;
    if_id_en     = 1'b0;
    id_ex_en     = 1'b0;
    ex_mem_en    = 1'b0;
    if_id_flush  = 1'b0;
    id_ex_bubble = 1'b0;
    int_take     = 1'b0;
    halted       = 1'b0;
    state_d      = state_q;
    drain_d      = drain_q;
    tgt_int_d    = tgt_int_q;
    code_d       = int_code;

    unique case (state_q)
      S_RUN: begin
        if (freeze) begin
          // whole pipe holds; nothing to do
        end else if (ex_redirect) begin
          {pc_en, if_id_en, id_ex_en, ex_mem_en} = 4'b1111;
          if_id_flush  = 1'b1;
          id_ex_bubble = 1'b1;
        end else if (load_use || ps_hazard) begin
          id_ex_en     = 1'b1;
          ex_mem_en    = 1'b1;
          id_ex_bubble = 1'b1;
        end else if (drain_req) begin
          id_ex_en     = 1'b1;
          ex_mem_en    = 1'b1;
          id_ex_bubble = 1'b1;
          state_d      = S_DRAIN;
          drain_d      = DW'(DRAIN_DEPTH);
          tgt_int_d    = id_interrupt && !id_halt;
          if (id_interrupt && !id_halt) code_d = id_immdt;
        end else begin
          {pc_en, if_id_en, id_ex_en, ex_mem_en} = 4'b1111;
        end
      end

      S_DRAIN: begin
        // EX and MEM only hold bubbles now, so a stale redirect is meaningless.
        if (!freeze) begin
          id_ex_en     = 1'b1;
          ex_mem_en    = 1'b1;
          id_ex_bubble = 1'b1;
          drain_d      = drain_q - DW'(1);
          if (drain_d == '0) state_d = tgt_int_q ? S_INT : S_HALTED;
        end
      end

      S_HALTED: begin
        halted = 1'b1;
        if (resume) begin
          pc_en       = 1'b1;
          if_id_flush = 1'b1;
          state_d     = S_RUN;
        end
      end

      S_INT: begin
        int_take     = 1'b1;
        pc_en        = 1'b1;
        id_ex_en     = 1'b1;
        ex_mem_en    = 1'b1;
        if_id_flush  = 1'b1;
        id_ex_bubble = 1'b1;
        state_d      = S_RUN;
      end

      default: state_d = S_RUN;
    endcase

    if (!n_rst) begin
      {pc_en, if_id_en, id_ex_en, ex_mem_en} = 4'b0000;
      if_id_flush  = 1'b1;
      id_ex_bubble = 1'b1;
      int_take     = 1'b0;
      halted       = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every flop samples
    // values from before this edge, regardless of statement order.
    if (!n_rst) begin
      state_q   <= S_RUN;
      drain_q   <= '0;
      tgt_int_q <= 1'b0;
      int_code  <= '0;
      stall_cnt <= '0;
    end else begin
      state_q   <= state_d;
      drain_q   <= drain_d;
      tgt_int_q <= tgt_int_d;
      int_code  <= code_d;
      if ((state_q != S_HALTED) && !pc_en && (stall_cnt != '1))
        stall_cnt <= stall_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Self-checking bench for pipeline_ctrl: directed hazard/HLT/INT scenarios plus
// randomized traffic, compared cycle by cycle against a behavioural model.
module tb_pipeline_ctrl;

  localparam int ADDR_W = 4;
  localparam int DEPTH  = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              n_rst;
  logic              id_valid, id_use_ra, id_use_rt, id_read_ps, id_halt, id_interrupt;
  logic [ADDR_W-1:0] id_rt_addr;
  logic [3:0]        id_immdt;
  logic              ex_valid, ex_use_rw, ex_write_ps, ex_is_load;
  logic [ADDR_W-1:0] ex_rw_addr;
  logic              ex_redirect, mem_req, mem_ready, resume;

  logic        pc_en, if_id_en, id_ex_en, ex_mem_en, if_id_flush, id_ex_bubble;
  logic        int_take, halted;
  logic [3:0]  int_code;
  logic [15:0] stall_cnt;

  logic       s_pc_en, s_if_id_en, s_id_ex_en, s_ex_mem_en, s_if_id_flush, s_id_ex_bubble;
  logic       s_int_take, s_halted;
  logic [3:0] s_int_code;
  logic [3:0] s_stall_cnt;

  pipeline_ctrl #(.ADDR_W(ADDR_W), .DRAIN_DEPTH(DEPTH), .CNT_W(16)) dut (
    .clk(clk), .n_rst(n_rst),
    .id_valid(id_valid), .id_use_ra(id_use_ra), .id_use_rt(id_use_rt),
    .id_read_ps(id_read_ps), .id_halt(id_halt), .id_interrupt(id_interrupt),
    .id_rt_addr(id_rt_addr), .id_immdt(id_immdt),
    .ex_valid(ex_valid), .ex_use_rw(ex_use_rw), .ex_write_ps(ex_write_ps),
    .ex_is_load(ex_is_load), .ex_rw_addr(ex_rw_addr), .ex_redirect(ex_redirect),
    .mem_req(mem_req), .mem_ready(mem_ready), .resume(resume),
    .pc_en(pc_en), .if_id_en(if_id_en), .id_ex_en(id_ex_en), .ex_mem_en(ex_mem_en),
    .if_id_flush(if_id_flush), .id_ex_bubble(id_ex_bubble),
    .int_take(int_take), .int_code(int_code), .halted(halted), .stall_cnt(stall_cnt)
  );

  // Narrow-counter copy so saturation is reachable within a short run.
  pipeline_ctrl #(.ADDR_W(ADDR_W), .DRAIN_DEPTH(DEPTH), .CNT_W(4)) dut_sat (
    .clk(clk), .n_rst(n_rst),
    .id_valid(id_valid), .id_use_ra(id_use_ra), .id_use_rt(id_use_rt),
    .id_read_ps(id_read_ps), .id_halt(id_halt), .id_interrupt(id_interrupt),
    .id_rt_addr(id_rt_addr), .id_immdt(id_immdt),
    .ex_valid(ex_valid), .ex_use_rw(ex_use_rw), .ex_write_ps(ex_write_ps),
    .ex_is_load(ex_is_load), .ex_rw_addr(ex_rw_addr), .ex_redirect(ex_redirect),
    .mem_req(mem_req), .mem_ready(mem_ready), .resume(resume),
    .pc_en(s_pc_en), .if_id_en(s_if_id_en), .id_ex_en(s_id_ex_en), .ex_mem_en(s_ex_mem_en),
    .if_id_flush(s_if_id_flush), .id_ex_bubble(s_id_ex_bubble),
    .int_take(s_int_take), .int_code(s_int_code), .halted(s_halted), .stall_cnt(s_stall_cnt)
  );

  int n_vec = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s @%0t: got 0x%0h expected 0x%0h", tag, $time, got, exp);
    end
  endtask

  // Behavioural model: halted / interrupt-pending flags plus a count of
  // non-frozen drain cycles still owed before the halt or interrupt lands.
  bit m_halted, m_int_next, m_to_int;
  int m_drain_left, m_code, m_cnt, m_cnt_s;

  function automatic bit m_freeze();
    return mem_req && !mem_ready;
  endfunction

  function automatic bit m_hazard();
    int  reads[$];
    bit  hit = 0;
    if (id_use_ra) reads.push_back(0);
    if (id_use_rt) reads.push_back(int'(id_rt_addr));
    foreach (reads[i]) if (reads[i] == int'(ex_rw_addr)) hit = 1;
    return id_valid && ex_valid && ((ex_is_load && ex_use_rw && hit) ||
                                    (id_read_ps && ex_write_ps));
  endfunction

  // {pc_en, if_id_en, id_ex_en, ex_mem_en, if_id_flush, id_ex_bubble, int_take, halted}
  function automatic logic [7:0] m_ctl();
    if (!n_rst)            return 8'b0000_1100;
    if (m_halted)          return resume ? 8'b1000_1001 : 8'b0000_0001;
    if (m_int_next)        return 8'b1011_1110;
    if (m_freeze())        return 8'b0000_0000;
    if (m_drain_left > 0)  return 8'b0011_0100;
    if (ex_redirect)       return 8'b1111_1100;
    if (m_hazard())        return 8'b0011_0100;
    if (id_valid && (id_halt || id_interrupt)) return 8'b0011_0100;
    return 8'b1111_0000;
  endfunction

  task automatic m_advance(input logic [7:0] ctl);
    if (!n_rst) begin
      m_halted = 0; m_int_next = 0; m_to_int = 0;
      m_drain_left = 0; m_code = 0; m_cnt = 0; m_cnt_s = 0;
      return;
    end
    if (!m_halted && !ctl[7]) begin
      if (m_cnt < 65535) m_cnt++;
      if (m_cnt_s < 15) m_cnt_s++;
    end
    if (m_halted) begin
      if (resume) m_halted = 0;
    end else if (m_int_next) begin
      m_int_next = 0;
    end else if (m_drain_left > 0) begin
      if (!m_freeze()) begin
        m_drain_left--;
        if (m_drain_left == 0) begin
          if (m_to_int) m_int_next = 1;
          else          m_halted   = 1;
        end
      end
    end else if (!m_freeze() && !ex_redirect && !m_hazard() &&
                 id_valid && (id_halt || id_interrupt)) begin
      m_drain_left = DEPTH;
      m_to_int     = id_interrupt && !id_halt;
      if (m_to_int) m_code = int'(id_immdt);
    end
  endtask

  task automatic idle();
    n_rst = 1; id_valid = 0; id_use_ra = 0; id_use_rt = 0; id_read_ps = 0;
    id_halt = 0; id_interrupt = 0; id_rt_addr = '0; id_immdt = '0;
    ex_valid = 0; ex_use_rw = 0; ex_write_ps = 0; ex_is_load = 0; ex_rw_addr = '0;
    ex_redirect = 0; mem_req = 0; mem_ready = 0; resume = 0;
  endtask

  // Inputs are already applied; check at the falling edge, then advance the model.
  task automatic cyc();
    logic [7:0] ctl;
    @(negedge clk);
    ctl = m_ctl();
    check("ctl", {24'd0, pc_en, if_id_en, id_ex_en, ex_mem_en,
                  if_id_flush, id_ex_bubble, int_take, halted}, {24'd0, ctl});
    check("int_code", 32'(int_code), 32'(m_code));
    check("stall_cnt", 32'(stall_cnt), 32'(m_cnt));
    check("stall_cnt_sat", 32'(s_stall_cnt), 32'(m_cnt_s));
    @(posedge clk);
    m_advance(ctl);
    #1;
  endtask

  task automatic idles(input int n);
    for (int i = 0; i < n; i++) begin idle(); cyc(); end
  endtask

  initial begin
    idle();
    n_rst = 0;
    @(posedge clk); #1;
    m_halted = 0; m_int_next = 0; m_to_int = 0;
    m_drain_left = 0; m_code = 0; m_cnt = 0; m_cnt_s = 0;
    cyc();
    idles(2);

    // Load-use on r3, then EX holds a bubble and flow resumes.
    idle(); id_valid = 1; id_use_rt = 1; id_rt_addr = 4'd3;
    ex_valid = 1; ex_is_load = 1; ex_use_rw = 1; ex_rw_addr = 4'd3; cyc();
    idle(); id_valid = 1; id_use_rt = 1; id_rt_addr = 4'd3; cyc();
    check("stall_after_load_use", 32'(stall_cnt), 32'd1);
    // ra read collides with a write to r0.
    idle(); id_valid = 1; id_use_ra = 1;
    ex_valid = 1; ex_is_load = 1; ex_use_rw = 1; ex_rw_addr = 4'd0; cyc();

    // EQ in EX with BR in ID, then the branch resolves taken.
    idle(); id_valid = 1; id_read_ps = 1; ex_valid = 1; ex_write_ps = 1; cyc();
    idle(); ex_redirect = 1; ex_valid = 1; cyc();
    idles(1);

    // resume outside HALTED has no effect.
    idle(); resume = 1; cyc();

    // HLT with a 3-cycle memory wait during drain, then resume.
    idle(); id_valid = 1; id_halt = 1; cyc();
    for (int i = 0; i < 3; i++) begin idle(); mem_req = 1; cyc(); end
    idles(3);
    check("halted_6_after_hlt", 32'(halted), 32'd1);
    idles(2);
    idle(); resume = 1; cyc();
    idles(1);

    // INT with code A.
    idle(); id_valid = 1; id_interrupt = 1; id_immdt = 4'hA; cyc();
    idles(2);
    check("int_take_3_after", 32'(int_take), 32'd1);
    check("int_code_A", 32'(int_code), 32'hA);
    idles(2);

    // Redirect and HLT together: HLT is flushed.
    idle(); ex_redirect = 1; id_valid = 1; id_halt = 1; cyc();
    idles(4);

    // Reset in the middle of a drain.
    idle(); id_valid = 1; id_interrupt = 1; id_immdt = 4'h5; cyc();
    idle(); n_rst = 0; cyc();
    idles(3);

    // Long freeze saturates the narrow counter.
    for (int i = 0; i < 20; i++) begin idle(); mem_req = 1; cyc(); end
    check("sat_hold", 32'(s_stall_cnt), 32'hF);
    idle(); n_rst = 0; cyc();

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      idle();
      n_rst        = ($urandom_range(0, 59) != 0);
      id_valid     = $urandom_range(0, 3) != 0;
      id_use_ra    = $urandom_range(0, 1) == 1;
      id_use_rt    = $urandom_range(0, 1) == 1;
      id_read_ps   = $urandom_range(0, 3) == 0;
      id_rt_addr   = ADDR_W'($urandom_range(0, 3));
      id_immdt     = 4'($urandom);
      case ($urandom_range(0, 15))
        0: id_halt = 1;
        1: id_interrupt = 1;
        default: ;
      endcase
      ex_valid     = $urandom_range(0, 1) == 1;
      ex_use_rw    = $urandom_range(0, 1) == 1;
      ex_is_load   = $urandom_range(0, 2) == 0;
      ex_write_ps  = $urandom_range(0, 3) == 0;
      ex_rw_addr   = ADDR_W'($urandom_range(0, 3));
      ex_redirect  = $urandom_range(0, 7) == 0;
      resume       = $urandom_range(0, 5) == 0;
      if (!m_halted && !m_int_next) begin
        mem_req   = $urandom_range(0, 3) == 0;
        mem_ready = $urandom_range(0, 1) == 1;
      end
      cyc();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/pipeline_ctrl.md
# pipeline_ctrl

Sequencing controller for the pipelined nand_cpu. It sits beside the IF/ID/EX/MEM pipeline registers, consumes the decoder output fields of the instruction in ID plus status from EX and MEM, and drives every stage enable, flush and bubble. It resolves load-use and predicate-state (ps) hazards, memory wait states and branch/jump redirects. It sequences the HLT and INT drain/halt/vector-entry flows.

## Interface
Parameters:
- ADDR_W, 4, register address width (matches rt_addr/rw_addr)
- DRAIN_DEPTH, 2, advancing cycles needed to empty EX and MEM after HLT/INT is held in ID
- CNT_W, 16, stall counter width

Ports (name, direction, width, meaning):
- clk  in  1  single clock, all state on rising edge
- n_rst  in  1  synchronous, active-low reset
- id_valid  in  1  ID holds a real instruction
- id_use_ra, id_use_rt, id_read_ps, id_halt, id_interrupt  in  1 each  decoder fields for ID instruction
- id_rt_addr  in  ADDR_W  decoder rt_addr
- id_immdt  in  4  decoder immdt (INT code)
- ex_valid, ex_use_rw, ex_write_ps, ex_is_load  in  1 each  EX instruction status
- ex_rw_addr  in  ADDR_W  EX destination
- ex_redirect  in  1  EX resolved a taken branch or jump this cycle
- mem_req, mem_ready  in  1 each  MEM stage LD/ST request / memory completion
- resume  in  1  restart request while halted
- pc_en, if_id_en, id_ex_en, ex_mem_en  out  1 each  stage register enables
- if_id_flush, id_ex_bubble  out  1 each  clear IF/ID; inject NOP into ID/EX
- int_take  out  1  one-cycle interrupt entry pulse
- int_code  out  4  captured INT immediate
- halted  out  1  core halted
- stall_cnt  out  CNT_W  saturating count of cycles with pc_en=0 outside HALTED

## Operation
- States are RUN, DRAIN, HALTED and INT. Registers are state, drain_cnt, int_pending_halt (drain target), int_code and stall_cnt.
- ra is register 0. The ID read set is {0 if id_use_ra} ∪ {id_rt_addr if id_use_rt}.
- RUN priority:
  1. Freeze: mem_req && !mem_ready. All four enables are 0, with no flush or bubble.
  2. Redirect: ex_redirect. pc_en=1, if_id_flush=1, id_ex_bubble=1, all other enables 1.
  3. Load-use: id_valid && ex_valid && ex_is_load && ex_use_rw && ex_rw_addr is in the read set. pc_en=if_id_en=0, id_ex_bubble=1, ex_mem_en=1.
  4. ps hazard: id_valid && id_read_ps && ex_valid && ex_write_ps. Same response as load-use (no ps forwarding).
  5. HLT/INT: id_valid && (id_halt || id_interrupt).
     - Transition to DRAIN with drain_cnt=DRAIN_DEPTH and target HALTED/INT.
     - int_code ← id_immdt on INT.
     - This cycle: pc_en=if_id_en=0, id_ex_bubble=1.
  6. Otherwise all enables are 1, with no flush or bubble.
- DRAIN:
  - pc_en=if_id_en=0, id_ex_bubble=1.
  - Freeze rule still applies.
  - drain_cnt decrements only on non-frozen cycles.
  - At 0, go to the target state.
  - ex_redirect is ignored (EX holds only bubbles).
- HALTED:
  - All enables are 0 and halted=1.
  - resume → RUN. On that transition cycle, if_id_flush=1 and pc_en=1, which discards HLT and refetches at PC.
- INT (exactly one cycle):
  - int_take=1, pc_en=1 (fetch unit loads vector from int_code), if_id_flush=1, id_ex_bubble=1.
  - Then RUN.
- stall_cnt increments in any cycle where state≠HALTED and pc_en=0, and saturates at all-ones.
- All control outputs are combinational from state and inputs.

## Timing
- Synchronous reset, when n_rst is sampled low:
  - state=RUN, drain_cnt=0, int_code=0, stall_cnt=0.
  - While n_rst=0, outputs are forced: enables 0, if_id_flush=1, id_ex_bubble=1, int_take=0, halted=0.
- First cycle after release: RUN with all enables 1.
- Latencies:
  - Load-use and ps stalls are exactly 1 cycle each (the hazard clears once EX advances).
  - Redirect costs 2 bubbles.
- HLT in ID at cycle t with no freezes: halted=1 at t+DRAIN_DEPTH+1.
- INT in ID at cycle t with no freezes: int_take pulses at t+DRAIN_DEPTH+1.
- Simultaneous events:
  - Freeze beats everything.
  - Redirect beats hazards and HLT/INT, so a younger HLT is flushed.
  - Hazard beats HLT/INT (HLT/INT accepted on the following cycle).
- resume outside HALTED is ignored.
- Reset mid-DRAIN or in HALTED returns to RUN, with int_code cleared.

## Test plan
- Load r3 (ex_is_load, ex_rw_addr=3) while ID is NND with id_rt_addr=3 → one cycle of pc_en=0 and id_ex_bubble=1, then full flow; stall_cnt=1.
- EQ in EX (ex_write_ps) with BR in ID (id_read_ps) → 1-cycle stall. Then ex_redirect=1 → if_id_flush=1 and id_ex_bubble=1 in the same cycle.
- HLT in ID, DRAIN_DEPTH=2, mem_req=1 with mem_ready=0 for 3 cycles during drain → halted asserts 6 cycles after HLT; resume → if_id_flush=1 and pc_en=1, then RUN.
- INT with id_immdt=4'hA → int_take=1 for exactly one cycle with int_code=4'hA, 3 cycles after acceptance.
- ex_redirect and id_halt asserted in the same cycle → no DRAIN entry; HLT flushed.
- n_rst low during DRAIN → next cycle RUN, int_code=0, stall_cnt=0. Separately, force stall_cnt to all-ones and keep stalling → it holds at 16'hFFFF.
